lsu_pipe: RTL and testbench

//  Parametrised load/store unit for the memory stage. Accepts one access per transaction from execute.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_pipe_align.sv | 46 ++++
 rtl/lsu_pipe.sv | 142 ++++++++++++++
 tb/tb_lsu_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} lsu_state_e;

  // Byte mask for the access size; zero when the size exceeds the datapath.
  function automatic logic [7:0] size_mask(input logic [2:0] f3, input int nb);
    logic [7:0] m;
    case (f3[1:0])
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    if ((1 << f3[1:0]) > nb) m = 8'h00;
    return m;
  endfunction

endpackage

// File: rtl/lsu_pipe_align.sv
// Combinational lane steering: store byte-enables/replication and load extract/extend.
module lsu_pipe_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NB    = XLEN / 8,
  parameter int OFF_W = $clog2(NB)
) (
  input  logic [2:0]       st_funct3,
  input  logic [OFF_W-1:0] st_off,
  input  logic [XLEN-1:0]  st_data,
  output logic [NB-1:0]    st_we,
  output logic [XLEN-1:0]  st_lanes,
  input  logic [2:0]       ld_funct3,
  input  logic [OFF_W-1:0] ld_off,
  input  logic [XLEN-1:0]  ld_rdata,
  output logic [XLEN-1:0]  ld_result
);

  logic [7:0]      st_mask;
  logic [XLEN-1:0] ld_shift;
  int              st_bytes;
  int              ld_bits;
  int              ld_sbit;

  assign st_mask  = size_mask(st_funct3, NB);
  assign st_we    = st_mask[NB-1:0] << st_off;
  assign ld_shift = ld_rdata >> {ld_off, 3'b000};

  // Byte lane i carries source byte (i mod size): replicates byte/half/word.
  always_comb begin
    st_lanes = '0;
    st_bytes = 1 << st_funct3[1:0];
    for (int i = 0; i < NB; i++)
      st_lanes[i*8 +: 8] = st_data[(i % st_bytes)*8 +: 8];
  end

  always_comb begin
    ld_result = ld_shift;
    ld_bits   = 8 << ld_funct3[1:0];
    ld_sbit   = (ld_bits > XLEN) ? XLEN - 1 : ld_bits - 1;
    for (int i = 0; i < XLEN; i++)
      if (i >= ld_bits) ld_result[i] = ld_funct3[2] ? 1'b0 : ld_shift[ld_sbit];
  end

endmodule

// File: rtl/lsu_pipe.sv
// Memory-stage load/store unit: one access at a time, valid/ready to the dcache,
// misalignment rejection and flush/drain handling.
module lsu_pipe
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [REG_W-1:0]    req_rd,
  output logic                dmem_req_valid,
  input  logic                dmem_req_ready,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [XLEN/8-1:0]   dmem_we,
  output logic [XLEN-1:0]     dmem_wdata,
  input  logic                dmem_rsp_valid,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic                wb_valid,
  output logic [REG_W-1:0]    wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                misalign,
  output logic [ADDR_W-1:0]   misalign_addr,
  output logic                stall
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_e       state_q;
  logic             store_q;
  logic [2:0]       f3_q;
  logic [OFF_W-1:0] off_q;
  logic [REG_W-1:0] rd_q;
  logic [NB-1:0]    st_we;
  logic [XLEN-1:0]  st_lanes;
  logic [XLEN-1:0]  ld_result;
  logic             accept;
  logic             bad;

  lsu_pipe_align #(.XLEN(XLEN)) u_align (
    .st_funct3 (req_funct3),
    .st_off    (req_addr[OFF_W-1:0]),
    .st_data   (req_wdata),
    .st_we     (st_we),
    .st_lanes  (st_lanes),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .ld_rdata  (dmem_rdata),
    .ld_result (ld_result)
  );

  assign req_ready      = (state_q == S_IDLE);
  assign dmem_req_valid = (state_q == S_REQ);
  assign stall          = (state_q != S_IDLE) | (req_valid & ~req_ready);
  assign accept         = req_ready & req_valid & ~flush;

  // Illegal encodings are rejected through the same path as misaligned ones.
  always_comb begin
    bad = 1'b0;
    case (req_funct3[1:0])
      2'd1:    bad = req_addr[0];
      2'd2:    bad = |req_addr[1:0];
      2'd3:    bad = |req_addr[2:0];
      default: bad = 1'b0;
    endcase
    if (size_mask(req_funct3, NB) == 8'h00)                 bad = 1'b1;
    if (req_store && req_funct3[2])                         bad = 1'b1;
    if (!req_store && req_funct3 == 3'b111)                 bad = 1'b1;
    if (!req_store && req_funct3 == F3_LWU && XLEN == 32)   bad = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      store_q       <= 1'b0;
      f3_q          <= '0;
      off_q         <= '0;
      rd_q          <= '0;
      dmem_addr     <= '0;
      dmem_we       <= '0;
      dmem_wdata    <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          if (bad) begin
            misalign      <= 1'b1;
            misalign_addr <= req_addr;
          end else begin
            store_q    <= req_store;
            f3_q       <= req_funct3;
            off_q      <= req_addr[OFF_W-1:0];
            rd_q       <= req_rd;
            dmem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            dmem_we    <= req_store ? st_we : '0;
            dmem_wdata <= st_lanes;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          if (dmem_req_ready) begin
            if (store_q)    state_q <= S_IDLE;
            else if (flush) state_q <= S_DRAIN;
            else            state_q <= S_WAIT;
          end else if (flush) begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (dmem_rsp_valid) begin
            if (!flush) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= ld_result;
            end
            state_q <= S_IDLE;
          end else if (flush) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: if (dmem_rsp_valid) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_pipe.sv
// Scoreboard bench for lsu_pipe: 32-bit instance for most cases, 64-bit for wide lanes.
module tb_lsu_pipe;
  import lsu_pkg::*;

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } sb_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0, req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, dmem_rdata = '0;
  logic [4:0]  req_rd = '0;
  logic        dmem_req_ready = 1'b0, dmem_rsp_valid = 1'b0;
  logic        req_ready, dmem_req_valid, wb_valid, misalign, stall;
  logic [31:0] dmem_addr, dmem_wdata, wb_data, misalign_addr;
  logic [3:0]  dmem_we;
  logic [4:0]  wb_rd;

  logic        flush_b = 1'b0, req_valid_b = 1'b0, req_store_b = 1'b0;
  logic [2:0]  req_funct3_b = '0;
  logic [31:0] req_addr_b = '0;
  logic [63:0] req_wdata_b = '0, dmem_rdata_b = '0;
  logic [4:0]  req_rd_b = '0;
  logic        dmem_req_ready_b = 1'b0, dmem_rsp_valid_b = 1'b0;
  logic        req_ready_b, dmem_req_valid_b, wb_valid_b, misalign_b, stall_b;
  logic [31:0] dmem_addr_b, misalign_addr_b;
  logic [63:0] dmem_wdata_b, wb_data_b;
  logic [7:0]  dmem_we_b;
  logic [4:0]  wb_rd_b;

  int  n_cmp = 0, n_bad = 0, wb_cnt = 0, cnt0;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  lsu_pipe #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign), .misalign_addr(misalign_addr),
    .stall(stall));

  lsu_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_store(req_store_b), .req_funct3(req_funct3_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .req_rd(req_rd_b), .dmem_req_valid(dmem_req_valid_b), .dmem_req_ready(dmem_req_ready_b),
    .dmem_addr(dmem_addr_b), .dmem_we(dmem_we_b), .dmem_wdata(dmem_wdata_b),
    .dmem_rsp_valid(dmem_rsp_valid_b), .dmem_rdata(dmem_rdata_b), .wb_valid(wb_valid_b),
    .wb_rd(wb_rd_b), .wb_data(wb_data_b), .misalign(misalign_b), .misalign_addr(misalign_addr_b),
    .stall(stall_b));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Writeback monitor pops the scoreboard on every result pulse.
  always @(negedge clk) begin : mon
    sb_t e;
    if (reset_n && wb_valid) begin
      wb_cnt++;
      if (sb_q.size() == 0) chk("wb_unexpected", wb_valid, 1'b0);
      else begin
        e = sb_q.pop_front();
        chk("wb_data", wb_data, e.data);
        chk("wb_rd", wb_rd, e.rd);
      end
    end
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = $urandom;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] rdata, input int dly, input logic [31:0] exp);
    issue(1'b0, f3, addr, 32'h0, rd);
    for (int i = 0; i <= dly; i++) begin
      chk("ld_req_valid", dmem_req_valid, 1'b1);
      chk("ld_addr", dmem_addr, addr & ~32'h3);
      chk("ld_stall", stall, 1'b1);
      if (i < dly) @(negedge clk);
    end
    chk("ld_we", dmem_we, 4'h0);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    chk("ld_wait_reqv", dmem_req_valid, 1'b0);
    dmem_rsp_valid = 1'b1; dmem_rdata = rdata;
    sb_q.push_back('{rd, exp});
    @(negedge clk);
    dmem_rsp_valid = 1'b0; dmem_rdata = $urandom;
    chk("wb_pulse", wb_valid, 1'b1);
    @(negedge clk);
    chk("wb_pulse_end", wb_valid, 1'b0);
    chk("ld_idle", req_ready, 1'b1);
  endtask

  task automatic ld64(input logic [2:0] f3, input logic [31:0] addr, input logic [63:0] rdata,
                      input logic [63:0] exp);
    req_valid_b = 1'b1; req_store_b = 1'b0; req_funct3_b = f3; req_addr_b = addr; req_rd_b = 5'd3;
    @(negedge clk);
    req_valid_b = 1'b0;
    chk("d64_reqv", dmem_req_valid_b, 1'b1);
    chk("d64_addr", dmem_addr_b, addr & ~32'h7);
    dmem_req_ready_b = 1'b1;
    @(negedge clk);
    dmem_req_ready_b = 1'b0; dmem_rsp_valid_b = 1'b1; dmem_rdata_b = rdata;
    @(negedge clk);
    dmem_rsp_valid_b = 1'b0;
    chk("d64_wb_valid", wb_valid_b, 1'b1);
    chk("d64_wb_data", wb_data_b, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_dmem", {dmem_req_valid, dmem_we, dmem_addr, dmem_wdata}, 64'h0);
    chk("rst_wb", {wb_valid, wb_rd, wb_data}, 64'h0);
    chk("rst_mis", {misalign, misalign_addr, stall}, 64'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Byte store lane replication and minimum store latency
    issue(1'b1, F3_SB, 32'h1003, 32'h0000_00AB, 5'd0);
    chk("sb_reqv", dmem_req_valid, 1'b1);
    chk("sb_addr", dmem_addr, 32'h1000);
    chk("sb_we", dmem_we, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    chk("sb_idle_stall", stall, 1'b0);
    chk("sb_idle_reqv", dmem_req_valid, 1'b0);

    issue(1'b1, F3_SH, 32'h1002, 32'h0000_BEEF, 5'd0);
    chk("sh_we", dmem_we, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;

    // Load extraction and extension
    do_load(F3_LH,  32'h2002, 5'd1, 32'h8001_0000, 0, 32'hFFFF_8001);
    do_load(F3_LHU, 32'h2002, 5'd2, 32'h8001_0000, 0, 32'h0000_8001);
    do_load(F3_LB,  32'h2001, 5'd4, 32'h0000_9A00, 0, 32'hFFFF_FF9A);
    do_load(F3_LBU, 32'h2003, 5'd5, 32'hF700_0000, 0, 32'h0000_00F7);
    do_load(F3_LW,  32'h2004, 5'd6, 32'h1234_5678, 0, 32'h1234_5678);

    // Misaligned word, then LD/LWU which are illegal on a 32-bit datapath
    issue(1'b0, F3_LW, 32'h3002, 32'h0, 5'd1);
    chk("mis_pulse", misalign, 1'b1);
    chk("mis_addr", misalign_addr, 32'h3002);
    chk("mis_no_req", dmem_req_valid, 1'b0);
    chk("mis_ready", req_ready, 1'b1);
    @(negedge clk);
    chk("mis_pulse_end", misalign, 1'b0);
    chk("mis_addr_hold", misalign_addr, 32'h3002);
    issue(1'b0, F3_LD, 32'h4000, 32'h0, 5'd1);
    chk("ld32_illegal", misalign, 1'b1);
    chk("ld32_no_req", dmem_req_valid, 1'b0);
    issue(1'b0, F3_LWU, 32'h4010, 32'h0, 5'd1);
    chk("lwu32_illegal", misalign_addr, 32'h4010);

    // Back-pressure from the dcache
    do_load(F3_LW, 32'h2008, 5'd9, 32'hCAFE_F00D, 5, 32'hCAFE_F00D);

    // Flush while waiting for the response: drained, no writeback
    cnt0 = wb_cnt;
    issue(1'b0, F3_LW, 32'h5000, 32'h0, 5'd7);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("drain_stall", stall, 1'b1);
    chk("drain_not_ready", req_ready, 1'b0);
    repeat (2) @(negedge clk);
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    chk("drain_no_wb", wb_valid, 1'b0);
    chk("drain_ready", req_ready, 1'b1);
    issue(1'b1, F3_SW, 32'h5004, 32'h1111_2222, 5'd0);
    chk("drain_next_reqv", dmem_req_valid, 1'b1);
    chk("drain_next_we", dmem_we, 4'hF);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    chk("drain_wb_count", wb_cnt, cnt0);

    // Flush before the handshake withdraws the request
    issue(1'b0, F3_LW, 32'h6000, 32'h0, 5'd8);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("wd_reqv", dmem_req_valid, 1'b0);
    chk("wd_ready", req_ready, 1'b1);

    // 64-bit datapath
    ld64(F3_LD, 32'h8, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    ld64(F3_LW, 32'hC, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);
    ld64(F3_LWU, 32'hC, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000);
    req_valid_b = 1'b1; req_store_b = 1'b1; req_funct3_b = F3_SH; req_addr_b = 32'h6;
    req_wdata_b = 64'h1234;
    @(negedge clk);
    req_valid_b = 1'b0;
    chk("d64_sh_we", dmem_we_b, 8'hC0);
    chk("d64_sh_wdata", dmem_wdata_b, 64'h1234_1234_1234_1234);
    dmem_req_ready_b = 1'b1;
    @(negedge clk);
    dmem_req_ready_b = 1'b0;

    // Asynchronous reset in the middle of a request
    issue(1'b1, F3_SW, 32'h7000, 32'hDEAD_BEEF, 5'd0);
    chk("ar_pre_reqv", dmem_req_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_reqv", dmem_req_valid, 1'b0);
    chk("ar_stall", stall, 1'b0);
    chk("ar_dmem", {dmem_we, dmem_addr, dmem_wdata}, 64'h0);
    chk("ar_ready", req_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
